// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data width.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_ADDR = 2'b01,
        RD_DATA = 2'b10,
        WRITE   = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Purely combinational, zero latency, no flow control.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merge_data
);

    logic [4:0]        w_bshift;
    logic [4:0]        w_hshift;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_mask;

    always_comb begin
        w_bshift     = {i_addr_lo, 3'b000};
        w_hshift     = {i_addr_lo[1], 4'b0000};
        w_byte       = 8'(i_rdata >> w_bshift);
        w_half       = 16'(i_rdata >> w_hshift);
        w_mask       = '0;
        o_load_data  = i_rdata;
        o_merge_data = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data  = {{24{i_signed & w_byte[7]}}, w_byte};
                w_mask       = DATA_W'(32'h0000_00FF) << w_bshift;
                o_merge_data = (i_rdata & ~w_mask) |
                               ((DATA_W'(i_wdata[7:0]) << w_bshift) & w_mask);
            end
            SZ_HALF: begin
                o_load_data  = {{16{i_signed & w_half[15]}}, w_half};
                w_mask       = DATA_W'(32'h0000_FFFF) << w_hshift;
                o_merge_data = (i_rdata & ~w_mask) |
                               ((DATA_W'(i_wdata[15:0]) << w_hshift) & w_mask);
            end
            default: begin
                o_load_data  = i_rdata;
                o_merge_data = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: error 1, word store 2, load 3, sub-word store (RMW) 4 cycles to resp_valid.
// req_ready only in IDLE, no response backpressure; LSU_MISALIGN_CHECK_EN enables misalign/size errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;
    logic              w_accept;
    logic              w_err;
    logic [1:0]        w_size_n;
    logic              w_word_store;

    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;
    logic              r_signed;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merge_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_err = (req_size == SZ_RSVD) ||
                   (req_size == SZ_HALF && req_addr[0]) ||
                   (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign w_err = 1'b0;
`endif

    // Reserved size only survives to here with the check disabled, where it acts as a word.
    assign w_size_n     = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_word_store = req_write && (w_size_n == SZ_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_write   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept && !w_err) begin
                    w_state_nxt = w_word_store ? WRITE : RD_ADDR;
                end
            end
            RD_ADDR: w_state_nxt = RD_DATA;
            RD_DATA: w_state_nxt = r_write ? WRITE : IDLE;
            WRITE: begin
                mem_write   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_size       <= SZ_BYTE;
            r_addr_lo    <= 2'b00;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            if (w_accept) begin
                r_size    <= w_size_n;
                r_addr_lo <= req_addr[1:0];
                r_signed  <= req_signed;
                r_write   <= req_write;
                r_wdata   <= req_wdata;
                if (w_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                end else begin
                    r_mem_addr <= req_addr[ADDR_W-1:2];
                    if (w_word_store) begin
                        r_mem_wdata <= req_wdata;
                    end
                end
            end
            if (r_state == RD_DATA) begin
                if (r_write) begin
                    r_mem_wdata <= w_merge_data;
                end else begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
            end
            if (r_state == WRITE) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= '0;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr_lo),
        .i_signed     (r_signed),
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic        mem_init;
    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    // Words 0 and 1 both hold 0x8899AABB so the half at 0x0002 reads 0x8899.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h5A5A_0000 | 32'(i);
            mem[0] <= 32'h8899_AABB;
            mem[1] <= 32'h8899_AABB;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    typedef struct {
        string       name;
        logic        reinit;
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr_cyc;
        logic [13:0] exp_wr_addr;
        logic [31:0] exp_wr_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic reinit, logic wr, logic [1:0] sz, logic sgn,
                                logic [15:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                                logic exp_err, int exp_lat, int exp_wr_cyc,
                                logic [13:0] exp_wr_addr, logic [31:0] exp_wr_data);
        vec_t v;
        v.name = name; v.reinit = reinit; v.wr = wr; v.sz = sz; v.sgn = sgn;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_wr_cyc = exp_wr_cyc;
        v.exp_wr_addr = exp_wr_addr; v.exp_wr_data = exp_wr_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_mem_init();
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    // Entered and left on a negedge; the next request is driven while resp_valid is still high.
    task automatic run_vec(input vec_t v);
        int          k;
        int          wr_cnt;
        int          wr_cyc;
        logic [13:0] wr_addr;
        logic [31:0] wr_data;
        logic        got;
        logic [31:0] got_rdata;
        logic        got_err;
        if (v.reinit) do_mem_init();
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.sz;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        chk({v.name, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1; wr_cnt = 0; wr_cyc = 0; wr_addr = '0; wr_data = '0;
        got = 1'b0; got_rdata = '0; got_err = 1'b0;
        while (!got && k <= 12) begin
            if (mem_write) begin
                wr_cnt++; wr_cyc = k; wr_addr = mem_addr; wr_data = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1; got_rdata = resp_rdata; got_err = resp_err;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=no_resp required=resp_within_%0d", v.name, v.exp_lat);
        end else begin
            chk({v.name, ".latency"}, 32'(k), 32'(v.exp_lat));
            chk({v.name, ".rdata"}, got_rdata, v.exp_rdata);
            chk({v.name, ".err"}, 32'(got_err), 32'(v.exp_err));
            chk({v.name, ".wr_count"}, 32'(wr_cnt), (v.exp_wr_cyc != 0) ? 32'd1 : 32'd0);
            if (v.exp_wr_cyc != 0) begin
                chk({v.name, ".wr_cycle"}, 32'(wr_cyc), 32'(v.exp_wr_cyc));
                chk({v.name, ".wr_addr"}, 32'(wr_addr), 32'(v.exp_wr_addr));
                chk({v.name, ".wr_data"}, wr_data, v.exp_wr_data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   wr_seen;
        vec_t v;

        vecs.push_back(mk("lb_s_5",    1, 0, 2'b00, 1, 16'h0005, 32'h0,        32'hFFFF_FFAA, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lhu_6",     1, 0, 2'b01, 0, 16'h0006, 32'h0,        32'h0000_8899, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sb_7",      1, 1, 2'b00, 0, 16'h0007, 32'h12,       32'h0,         0, 4, 3, 14'd1, 32'h1299_AABB));
        vecs.push_back(mk("lw_4_sb",   0, 0, 2'b10, 0, 16'h0004, 32'h0,        32'h1299_AABB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sw_8",      1, 1, 2'b10, 0, 16'h0008, 32'hDEADBEEF, 32'h0,         0, 2, 1, 14'd2, 32'hDEAD_BEEF));
        vecs.push_back(mk("lw_8_b2b",  0, 0, 2'b10, 0, 16'h0008, 32'h0,        32'hDEAD_BEEF, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lbu_4",     1, 0, 2'b00, 0, 16'h0004, 32'h0,        32'h0000_00BB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lb_s_4",    0, 0, 2'b00, 1, 16'h0004, 32'h0,        32'hFFFF_FFBB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lh_s_6",    0, 0, 2'b01, 1, 16'h0006, 32'h0,        32'hFFFF_8899, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lh_s_4",    0, 0, 2'b01, 1, 16'h0004, 32'h0,        32'hFFFF_AABB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sh_6",      0, 1, 2'b01, 0, 16'h0006, 32'hABCD5566, 32'h0,         0, 4, 3, 14'd1, 32'h5566_AABB));
        vecs.push_back(mk("lw_4_sh",   0, 0, 2'b10, 0, 16'h0004, 32'h0,        32'h5566_AABB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sb_4",      1, 1, 2'b00, 0, 16'h0004, 32'hFFFFFF77, 32'h0,         0, 4, 3, 14'd1, 32'h8899_AA77));
        vecs.push_back(mk("lw_4_sb4",  0, 0, 2'b10, 0, 16'h0004, 32'h0,        32'h8899_AA77, 0, 3, 0, 14'd0, 32'h0));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk("lhu_3",     1, 0, 2'b01, 0, 16'h0003, 32'h0,        32'h0,         1, 1, 0, 14'd0, 32'h0));
        vecs.push_back(mk("rsvd_4",    0, 0, 2'b11, 0, 16'h0004, 32'h0,        32'h0,         1, 1, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lw_5",      0, 0, 2'b10, 0, 16'h0005, 32'h0,        32'h0,         1, 1, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sw_6",      0, 1, 2'b10, 0, 16'h0006, 32'hCAFEF00D, 32'h0,         1, 1, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lw_4_chk",  0, 0, 2'b10, 0, 16'h0004, 32'h0,        32'h8899_AABB, 0, 3, 0, 14'd0, 32'h0));
`else
        vecs.push_back(mk("lhu_3",     1, 0, 2'b01, 0, 16'h0003, 32'h0,        32'h0000_8899, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("rsvd_4",    0, 0, 2'b11, 0, 16'h0004, 32'h0,        32'h8899_AABB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("lw_5",      0, 0, 2'b10, 0, 16'h0005, 32'h0,        32'h8899_AABB, 0, 3, 0, 14'd0, 32'h0));
        vecs.push_back(mk("sw_6",      0, 1, 2'b10, 0, 16'h0006, 32'hCAFEF00D, 32'h0,         0, 2, 1, 14'd1, 32'hCAFE_F00D));
        vecs.push_back(mk("lw_4_chk",  0, 0, 2'b10, 0, 16'h0004, 32'h0,        32'hCAFE_F00D, 0, 3, 0, 14'd0, 32'h0));
`endif

        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.req_ready",  32'(req_ready),  32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata,      32'd0);
        chk("rst.resp_err",   32'(resp_err),   32'd0);
        chk("rst.mem_write",  32'(mem_write),  32'd0);
        chk("rst.mem_addr",   32'(mem_addr),   32'd0);
        chk("rst.mem_wdata",  mem_wdata,       32'd0);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end
        @(negedge clk);

        // Reset lands while a byte store sits in RD_DATA: the write must never issue.
        do_mem_init();
        wr_seen    = 0;
        req_valid  = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr   = 16'h0007; req_wdata = 32'h0000_0012;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_write) wr_seen++;
        @(negedge clk);
        if (mem_write) wr_seen++;
        rst = 1'b1;
        @(negedge clk);
        if (mem_write) wr_seen++;
        chk("rstmid.resp_valid_in_rst", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid.req_ready_after", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (mem_write) wr_seen++;
            chk($sformatf("rstmid.resp_valid_c%0d", c), 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        chk("rstmid.wr_count", 32'(wr_seen), 32'd0);
        v = mk("rstmid.lw_4", 0, 0, 2'b10, 0, 16'h0004, 32'h0, 32'h8899_AABB, 0, 3, 0, 14'd0, 32'h0);
        run_vec(v);
        @(negedge clk);
        chk("final.resp_pulse_end", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
